// File: rtl/uart_csr_arbiter_if.sv
// Signal bundle between the CSR requesters, uart_csr_arbiter and the UART CSR port.
// The arbiter takes the slave modport; the requesters plus the UART take the master side.
interface uart_csr_arbiter_if #(
    parameter int NM = 2,
    parameter int AW = 14,
    parameter int DW = 32
);
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_we;
    logic [NM*AW-1:0] m_a;
    logic [NM*DW-1:0] m_di;
    logic [NM-1:0]    m_lock;
    logic [NM-1:0]    m_ack;
    logic [DW-1:0]    m_do;
    logic [AW-1:0]    csr_a;
    logic             csr_we;
    logic [DW-1:0]    csr_di;
    logic [DW-1:0]    csr_do;

    modport slave (
        input  m_req, m_we, m_a, m_di, m_lock, csr_do,
        output m_ack, m_do, csr_a, csr_we, csr_di
    );

    modport master (
        output m_req, m_we, m_a, m_di, m_lock, csr_do,
        input  m_ack, m_do, csr_a, csr_we, csr_di
    );
endinterface

// File: rtl/uart_csr_arbiter.sv
// Round-robin arbiter sharing the UART CSR port among NM requesters, one transaction at a time.
// Optional grant locking for atomic read-modify-write is enabled by defining UART_ARB_LOCK_EN.
module uart_csr_arbiter #(
    parameter int NM = 2,
    parameter int AW = 14,
    parameter int DW = 32
) (
    input logic                  sys_clk,
    input logic                  sys_rst,
    uart_csr_arbiter_if.slave    bus
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] last;
    logic [IW-1:0] cand;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;

`ifdef UART_ARB_LOCK_EN
    logic lock;
`else
    logic unused_lock;
    assign unused_lock = ^bus.m_lock;
`endif

    // Search from last+1 upward; iterating downward lets the nearest requester overwrite farther ones.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last;
        cand      = last;
        for (int i = NM; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % NM);
            if (bus.m_req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
`ifdef UART_ARB_LOCK_EN
        if (lock && bus.m_req[last]) begin
            gnt_valid = 1'b1;
            gnt_idx   = last;
        end
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            last       <= IW'(NM - 1);
            bus.m_ack  <= '0;
            bus.m_do   <= '0;
            bus.csr_a  <= '0;
            bus.csr_we <= 1'b0;
            bus.csr_di <= '0;
`ifdef UART_ARB_LOCK_EN
            lock       <= 1'b0;
`endif
        end else begin
            bus.m_ack  <= '0;
            bus.csr_we <= 1'b0;
            case (state)
                IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    if (lock && !bus.m_req[last]) begin
                        lock <= 1'b0;
                    end
`endif
                    if (gnt_valid) begin
                        last       <= gnt_idx;
                        bus.csr_we <= bus.m_we[gnt_idx];
                        bus.csr_a  <= bus.m_a[int'(gnt_idx)*AW +: AW];
                        bus.csr_di <= bus.m_di[int'(gnt_idx)*DW +: DW];
                        state      <= ISSUE;
`ifdef UART_ARB_LOCK_EN
                        if (!bus.m_lock[gnt_idx]) begin
                            lock <= 1'b0;
                        end
`endif
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                // UART read data is valid now, one cycle after csr_a was presented.
                CAPTURE: begin
                    bus.m_do        <= bus.csr_do;
                    bus.m_ack[last] <= 1'b1;
                    state           <= ACK;
                end
                ACK: begin
`ifdef UART_ARB_LOCK_EN
                    lock <= bus.m_lock[last];
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_csr_arbiter.sv
// Scoreboard bench for uart_csr_arbiter: a 2-requester instance for most scenarios plus a 4-requester one for rotation order.
module tb_uart_csr_arbiter;
    localparam int NM = 2;
    localparam int AW = 14;
    localparam int DW = 32;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t sb4[$];

    always #5 clk = ~clk;

    uart_csr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();
    uart_csr_arbiter_if #(.NM(4), .AW(AW), .DW(DW)) bus4 ();

    uart_csr_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));
    uart_csr_arbiter #(.NM(4), .AW(AW), .DW(DW)) dut4 (.sys_clk(clk), .sys_rst(rst), .bus(bus4));

    function automatic logic [31:0] uart_model(input logic [AW-1:0] a);
        return 32'hD00D_0000 ^ {18'h0, a};
    endfunction

    // UART CSR read port: registered data, one cycle after the address.
    always @(posedge clk) begin
        bus.csr_do  <= uart_model(bus.csr_a);
        bus4.csr_do <= uart_model(bus4.csr_a);
    end

    task automatic set_req(input int i, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] di, input logic lk);
        bus.m_req[i]         = req;
        bus.m_we[i]          = we;
        bus.m_a[i*AW +: AW]  = a;
        bus.m_di[i*DW +: DW] = di;
        bus.m_lock[i]        = lk;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.m_req = '0;  bus.m_we = '0;  bus.m_a = '0;  bus.m_di = '0;  bus.m_lock = '0;
        bus4.m_req = '0; bus4.m_we = '0; bus4.m_a = '0; bus4.m_di = '0; bus4.m_lock = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.m_ack !== 2'b00) begin bad++; $display("FAIL reset_m_ack got=%b want=00", bus.m_ack); end
        total++; if (bus.m_do !== 32'h0) begin bad++; $display("FAIL reset_m_do got=%h want=0", bus.m_do); end
        total++; if (bus.csr_a !== 14'h0) begin bad++; $display("FAIL reset_csr_a got=%h want=0", bus.csr_a); end
        total++; if (bus.csr_we !== 1'b0) begin bad++; $display("FAIL reset_csr_we got=%b want=0", bus.csr_we); end
        total++; if (bus.csr_di !== 32'h0) begin bad++; $display("FAIL reset_csr_di got=%h want=0", bus.csr_di); end
        total++; if (bus4.m_ack !== 4'b0) begin bad++; $display("FAIL reset_m_ack4 got=%b want=0000", bus4.m_ack); end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        exp_t e;
        set_req(0, 1'b1, 1'b0, 14'h0001, 32'h0, 1'b0);
        sb.push_back('{0, uart_model(14'h0001)});
        @(negedge clk);
        total++; if (bus.csr_a !== 14'h0001) begin bad++; $display("FAIL read_csr_a got=%h want=0001", bus.csr_a); end
        total++; if (bus.csr_we !== 1'b0) begin bad++; $display("FAIL read_we_issue got=%b want=0", bus.csr_we); end
        @(negedge clk);
        total++; if (bus.csr_we !== 1'b0 || bus.m_ack !== 2'b00) begin bad++; $display("FAIL read_capture we=%b ack=%b want 0/00", bus.csr_we, bus.m_ack); end
        @(negedge clk);
        e = sb.pop_front();
        total++; if (bus.m_ack !== 2'(1 << e.idx)) begin bad++; $display("FAIL read_ack got=%b want_idx=%0d", bus.m_ack, e.idx); end
        total++; if (bus.m_do !== e.data) begin bad++; $display("FAIL read_m_do got=%h want=%h", bus.m_do, e.data); end
        set_req(0, 1'b0, 1'b0, 14'h0001, 32'h0, 1'b0);
        @(negedge clk);
        total++; if (bus.m_ack !== 2'b00) begin bad++; $display("FAIL read_ack_width got=%b want=00", bus.m_ack); end
    endtask

    task automatic test_single_write;
        exp_t e;
        set_req(1, 1'b1, 1'b1, 14'h0000, 32'h41, 1'b0);
        sb.push_back('{1, uart_model(14'h0000)});
        @(negedge clk);
        total++; if (bus.csr_we !== 1'b1 || bus.csr_di !== 32'h41 || bus.csr_a !== 14'h0)
            begin bad++; $display("FAIL write_issue we=%b di=%h a=%h want 1/41/0", bus.csr_we, bus.csr_di, bus.csr_a); end
        @(negedge clk);
        total++; if (bus.csr_we !== 1'b0) begin bad++; $display("FAIL write_single_pulse got=%b want=0", bus.csr_we); end
        @(negedge clk);
        e = sb.pop_front();
        total++; if (bus.m_ack !== 2'(1 << e.idx) || bus.m_do !== e.data)
            begin bad++; $display("FAIL write_ack ack=%b do=%h want idx=%0d do=%h", bus.m_ack, bus.m_do, e.idx, e.data); end
        set_req(1, 1'b0, 1'b0, 14'h0000, 32'h0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_contention;
        exp_t e;
        int seen = 0;
        int last_c = 0;
        set_req(0, 1'b1, 1'b0, 14'h0010, 32'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 14'h0020, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{0, uart_model(14'h0010)});
            sb.push_back('{1, uart_model(14'h0020)});
        end
        for (int c = 0; c < 40 && seen < 4; c++) begin
            @(negedge clk);
            if (bus.m_ack !== 2'b00) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL contention_extra ack=%b", bus.m_ack); end
                else begin
                    e = sb.pop_front();
                    if (bus.m_ack !== 2'(1 << e.idx) || bus.m_do !== e.data)
                        begin bad++; $display("FAIL contention_ack ack=%b do=%h want idx=%0d do=%h", bus.m_ack, bus.m_do, e.idx, e.data); end
                end
                if (seen > 0) begin
                    total++; if (c - last_c != 4) begin bad++; $display("FAIL contention_spacing got=%0d want=4", c - last_c); end
                end
                last_c = c;
                seen++;
                if (seen == 4) begin
                    set_req(0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
                    set_req(1, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
                end
            end
        end
        total++; if (seen != 4) begin bad++; $display("FAIL contention_timeout acks=%0d want=4", seen); end
        @(negedge clk);
    endtask

    task automatic test_rotation_nm4;
        exp_t e;
        int seen = 0;
        bus4.m_a   = {14'd3, 14'd2, 14'd1, 14'd0};
        bus4.m_req = 4'hF;
        for (int k = 0; k < 5; k++) sb4.push_back('{k % 4, uart_model(14'(k % 4))});
        for (int c = 0; c < 60 && seen < 5; c++) begin
            @(negedge clk);
            if (bus4.m_ack !== 4'b0) begin
                total++;
                if (sb4.size() == 0) begin bad++; $display("FAIL nm4_extra ack=%b", bus4.m_ack); end
                else begin
                    e = sb4.pop_front();
                    if (bus4.m_ack !== 4'(1 << e.idx) || bus4.m_do !== e.data)
                        begin bad++; $display("FAIL nm4_order ack=%b do=%h want idx=%0d do=%h", bus4.m_ack, bus4.m_do, e.idx, e.data); end
                end
                seen++;
                if (seen == 5) bus4.m_req = 4'h0;
            end
        end
        total++; if (seen != 5) begin bad++; $display("FAIL nm4_timeout acks=%0d want=5", seen); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        exp_t e;
        int seen = 0;
        set_req(0, 1'b1, 1'b1, 14'h0033, 32'h77, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.m_ack !== 2'b00 || bus.m_do !== 32'h0 || bus.csr_a !== 14'h0 || bus.csr_we !== 1'b0 || bus.csr_di !== 32'h0)
            begin bad++; $display("FAIL midreset_values ack=%b do=%h a=%h we=%b di=%h want all 0", bus.m_ack, bus.m_do, bus.csr_a, bus.csr_we, bus.csr_di); end
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 14'h0034, 32'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 14'h0035, 32'h0, 1'b0);
        sb.push_back('{0, uart_model(14'h0034)});
        sb.push_back('{1, uart_model(14'h0035)});
        for (int c = 0; c < 30 && seen < 2; c++) begin
            @(negedge clk);
            if (bus.m_ack !== 2'b00) begin
                e = sb.pop_front();
                total++; if (bus.m_ack !== 2'(1 << e.idx) || bus.m_do !== e.data)
                    begin bad++; $display("FAIL midreset_grant ack=%b do=%h want idx=%0d do=%h", bus.m_ack, bus.m_do, e.idx, e.data); end
                set_req(e.idx, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
                seen++;
            end
        end
        total++; if (seen != 2) begin bad++; $display("FAIL midreset_timeout acks=%0d want=2", seen); end
        @(negedge clk);
    endtask

    task automatic test_drop_after_grant;
        exp_t e;
        set_req(0, 1'b1, 1'b0, 14'h0005, 32'h0, 1'b0);
        sb.push_back('{0, uart_model(14'h0005)});
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
        @(negedge clk);
        total++; if (bus.m_ack !== 2'b00) begin bad++; $display("FAIL drop_early_ack got=%b want=00", bus.m_ack); end
        @(negedge clk);
        e = sb.pop_front();
        total++; if (bus.m_ack !== 2'(1 << e.idx) || bus.m_do !== e.data)
            begin bad++; $display("FAIL drop_ack ack=%b do=%h want idx=%0d do=%h", bus.m_ack, bus.m_do, e.idx, e.data); end
        repeat (4) @(negedge clk);
        total++; if (bus.m_ack !== 2'b00 || bus.csr_a !== 14'h0005)
            begin bad++; $display("FAIL drop_no_repeat ack=%b a=%h want 00/0005", bus.m_ack, bus.csr_a); end
    endtask

    task automatic test_lock;
        exp_t e;
        int seen = 0;
        int zero_acks = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 14'h0011, 32'h0, 1'b1);
        set_req(1, 1'b1, 1'b0, 14'h0022, 32'h0, 1'b0);
        sb.push_back('{0, uart_model(14'h0011)});
`ifdef UART_ARB_LOCK_EN
        sb.push_back('{0, uart_model(14'h0012)});
        sb.push_back('{1, uart_model(14'h0022)});
`else
        sb.push_back('{1, uart_model(14'h0022)});
        sb.push_back('{0, uart_model(14'h0012)});
`endif
        for (int c = 0; c < 40 && seen < 3; c++) begin
            @(negedge clk);
            if (bus.m_ack !== 2'b00) begin
                e = sb.pop_front();
                total++; if (bus.m_ack !== 2'(1 << e.idx) || bus.m_do !== e.data)
                    begin bad++; $display("FAIL lock_order ack=%b do=%h want idx=%0d do=%h", bus.m_ack, bus.m_do, e.idx, e.data); end
                if (bus.m_ack[0]) begin
                    zero_acks++;
                    if (zero_acks == 1) set_req(0, 1'b1, 1'b1, 14'h0012, 32'h99, 1'b0);
                    else set_req(0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
                end
                if (bus.m_ack[1]) set_req(1, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
                seen++;
            end
        end
        total++; if (seen != 3) begin bad++; $display("FAIL lock_timeout acks=%0d want=3", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_rotation_nm4();
        test_reset_mid_op();
        test_drop_after_grant();
        test_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
